// File: rtl/move_select_if.sv
// move_select_if: groups the signals between move_select and its surroundings.
//   Buttons (raw, asynchronous, active-high): btn_left, btn_right, btn_up, btn_down, btn_place
//   Board inputs: X, O (9-bit, bit i = cell i, row-major, bit 0 top-left), game_over
//   Outputs: C (one-hot cell to write), writeEn (write strobe), cursor (one-hot),
//            reject (one-cycle pulse on a refused placement)
// The master modport is the stimulus/board side. The slave modport is move_select.
interface move_select_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       btn_place;
  logic [8:0] X;
  logic [8:0] O;
  logic       game_over;
  logic [8:0] C;
  logic       writeEn;
  logic [8:0] cursor;
  logic       reject;

  modport master (
    output btn_left, btn_right, btn_up, btn_down, btn_place, X, O, game_over,
    input  C, writeEn, cursor, reject
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down, btn_place, X, O, game_over,
    output C, writeEn, cursor, reject
  );
endinterface

// File: rtl/move_select.sv
// move_select: push-button front end for the tic-tac-toe game state register.
// Each raw button is synchronized, debounced and edge-detected. The direction presses move a
// cursor around the 3x3 board with wrap-around. A place press on an empty cell, while the game is
// still running, drives a one-hot C and holds writeEn high for WE_CYCLES cycles. writeEn then
// stays low for at least WE_CYCLES cycles. The block re-arms only after place is released, so a
// long press commits exactly one move. A place press on an occupied cell, or after game end,
// pulses reject instead.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    move_select_if.slave (buttons, X/O boards, game_over, C, writeEn, cursor, reject)
//
// Optional feature: define MOVE_SELECT_AUTO_ADVANCE_EN to move the cursor to the next empty
// cell after each committed move.
module move_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned WE_CYCLES       = 4
) (
  input  logic          clk,
  input  logic          reset,
  move_select_if.slave  bus
);

  localparam int NumBtn   = 5;
  localparam int BtnLeft  = 0;
  localparam int BtnRight = 1;
  localparam int BtnUp    = 2;
  localparam int BtnDown  = 3;
  localparam int BtnPlace = 4;

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TmrW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] TmrLoad = TmrW'(WE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StGap,
    StHold
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------------------------
  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q;
  logic [NumBtn-1:0] sync2_q;
  logic [NumBtn-1:0] db_q;
  logic [NumBtn-1:0] db_prev_q;
  logic [CntW-1:0]   cnt_q [NumBtn];
  logic [NumBtn-1:0] press;

  assign btn_raw = {bus.btn_place, bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < NumBtn; i++) begin
        // The counter only advances while the synchronized level disagrees with the debounced
        // level. Any agreement restarts the stability window.
        if (sync2_q[i] != db_q[i]) begin
          if (cnt_q[i] == CntMax) begin
            db_q[i]  <= ~db_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // One-cycle press on the rising edge of each debounced level.
  assign press = db_q & ~db_prev_q;

  // ---------------------------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------------------------
  function automatic logic [8:0] onehot(input logic [3:0] idx);
    return 9'b1 << idx;
  endfunction

  // Apply the highest-priority direction press. Place is handled by the FSM before this.
  function automatic logic [3:0] step(input logic [3:0] idx, input logic [NumBtn-1:0] p);
    logic [3:0] col;
    col = idx % 4'd3;
    if (p[BtnLeft]) begin
      return (col == 4'd0) ? idx + 4'd2 : idx - 4'd1;
    end else if (p[BtnRight]) begin
      return (col == 4'd2) ? idx - 4'd2 : idx + 4'd1;
    end else if (p[BtnUp]) begin
      return (idx < 4'd3) ? idx + 4'd6 : idx - 4'd3;
    end else if (p[BtnDown]) begin
      return (idx > 4'd5) ? idx - 4'd6 : idx + 4'd3;
    end
    return idx;
  endfunction

`ifdef MOVE_SELECT_AUTO_ADVANCE_EN
  // Lowest-index empty cell strictly after idx, wrapping 8 -> 0. Returns idx if the board is full.
  function automatic logic [3:0] next_empty(input logic [3:0] idx, input logic [8:0] occ);
    logic [3:0] res;
    logic       found;
    logic [4:0] s;
    res   = idx;
    found = 1'b0;
    for (int k = 1; k < 9; k++) begin
      s = {1'b0, idx} + 5'(k);
      if (s > 5'd8) begin
        s = s - 5'd9;
      end
      if (!found && !occ[s[3:0]]) begin
        res   = s[3:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction
`endif

  // ---------------------------------------------------------------------------------------------
  // Move sequencing FSM
  // ---------------------------------------------------------------------------------------------
  state_e          state_q;
  logic [3:0]      cursor_q;
  logic [8:0]      c_q;
  logic            we_q;
  logic            reject_q;
  logic [TmrW-1:0] tmr_q;
  logic [8:0]      occ;

  assign occ = bus.X | bus.O;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cursor_q <= 4'd4;
      c_q      <= '0;
      we_q     <= 1'b0;
      reject_q <= 1'b0;
      tmr_q    <= '0;
    end else begin
      reject_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Place wins over every direction. Any other press in the same cycle is dropped.
          if (press[BtnPlace]) begin
            if (bus.game_over || occ[cursor_q]) begin
              reject_q <= 1'b1;
            end else begin
              c_q     <= onehot(cursor_q);
              we_q    <= 1'b1;
              tmr_q   <= TmrLoad;
              state_q <= StWrite;
            end
          end else begin
            cursor_q <= step(cursor_q, press);
          end
        end
        StWrite: begin
          if (tmr_q == '0) begin
            we_q    <= 1'b0;
            tmr_q   <= TmrLoad;
            state_q <= StGap;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        StGap: begin
          // Guarantees the state register sees writeEn low before any later move.
          if (tmr_q == '0) begin
            state_q <= StHold;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        StHold: begin
          if (!db_q[BtnPlace]) begin
            c_q     <= '0;
            state_q <= StIdle;
`ifdef MOVE_SELECT_AUTO_ADVANCE_EN
            cursor_q <= next_empty(cursor_q, occ);
`endif
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.C       = c_q;
  assign bus.writeEn = we_q;
  assign bus.reject  = reject_q;
  assign bus.cursor  = onehot(cursor_q);

endmodule

// File: tb/tb_move_select.sv
// Self-checking bench for move_select with DEBOUNCE_CYCLES=4 and WE_CYCLES=4.
// The stimulus pushes the expected output events onto a scoreboard queue. A negedge monitor turns
// output changes into events and compares each one with the head of the queue.
module tb_move_select;
  localparam int Deb = 4;
  localparam int We  = 4;

  localparam int KCursor = 1;
  localparam int KC      = 2;
  localparam int KWeLen  = 3;
  localparam int KReject = 4;

  typedef struct {
    int         kind;
    logic [8:0] val;
    string      tag;
  } exp_t;

  logic clk;
  logic reset;
  move_select_if bus ();

  move_select #(
    .DEBOUNCE_CYCLES(Deb),
    .WE_CYCLES      (We)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_unexp = 0;
  bit   mon_en  = 1'b0;
  int   cur     = 4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int kind, input logic [8:0] val, input string tag);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic emit(input int kind, input logic [8:0] val);
    exp_t e;
    if (sb.size() == 0) begin
      n_unexp++;
      $display("unexpected event kind %0d value %0h at %0t", kind, val, $time);
    end else begin
      e = sb.pop_front();
      check(e.tag, {kind[3:0], 19'b0, val}, {e.kind[3:0], 19'b0, e.val});
    end
  endtask

  // Output monitor
  initial begin
    logic [8:0] p_cur;
    logic [8:0] p_c;
    logic       p_we;
    int         we_len;
    int         gap;
    bit         seen_pulse;
    p_cur      = 9'h010;
    p_c        = '0;
    p_we       = 1'b0;
    we_len     = 0;
    gap        = 0;
    seen_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.cursor != p_cur) emit(KCursor, bus.cursor);
        if (bus.C != p_c) emit(KC, bus.C);
        if (p_we && !bus.writeEn) emit(KWeLen, 9'(we_len));
        if (!p_we && bus.writeEn && seen_pulse) check("we_gap", 32'(gap >= We), 32'd1);
        if (bus.reject) emit(KReject, bus.C);
      end
      if (bus.writeEn) begin
        we_len = p_we ? we_len + 1 : 1;
      end else begin
        gap = p_we ? 1 : gap + 1;
        if (p_we) seen_pulse = 1'b1;
      end
      p_cur = bus.cursor;
      p_c   = bus.C;
      p_we  = bus.writeEn;
    end
  end

  // Bits: 0 left, 1 right, 2 up, 3 down, 4 place.
  task automatic drive(input logic [4:0] m);
    bus.btn_left  = m[0];
    bus.btn_right = m[1];
    bus.btn_up    = m[2];
    bus.btn_down  = m[3];
    bus.btn_place = m[4];
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    @(negedge clk);
    drive(m);
    repeat (hold) @(negedge clk);
    drive(5'b0);
    repeat (14) @(negedge clk);
  endtask

  task automatic move(input int dir);
    int row;
    int col;
    row = cur / 3;
    col = cur % 3;
    case (dir)
      0:       col = (col + 2) % 3;
      1:       col = (col + 1) % 3;
      2:       row = (row + 2) % 3;
      default: row = (row + 1) % 3;
    endcase
    cur = row * 3 + col;
    push(KCursor, 9'(1) << cur, "cursor_move");
    press(5'(1) << dir, 10);
  endtask

  function automatic int adv(input int c, input logic [8:0] occ);
    for (int k = 1; k < 9; k++) begin
      if (!occ[(c + k) % 9]) return (c + k) % 9;
    end
    return c;
  endfunction

  // Expected events of one accepted placement on the current cell.
  task automatic expect_place(input logic [8:0] occ);
    int nc;
    push(KC, 9'(1) << cur, "c_set");
    push(KWeLen, 9'(We), "we_len");
    nc = cur;
`ifdef MOVE_SELECT_AUTO_ADVANCE_EN
    nc = adv(cur, occ);
`endif
    if (nc != cur) push(KCursor, 9'(1) << nc, "cursor_adv");
    cur = nc;
    push(KC, 9'h000, "c_clr");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset         = 1'b0;
    drive(5'b0);
    bus.X         = '0;
    bus.O         = '0;
    bus.game_over = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cursor", 32'(bus.cursor), 32'h010);
    check("rst_c", 32'(bus.C), 32'h0);
    check("rst_we", 32'(bus.writeEn), 32'h0);
    check("rst_reject", 32'(bus.reject), 32'h0);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_cursor", 32'(bus.cursor), 32'h010);

    // Cursor moves: right x3 wraps within row 1, up x2 wraps within column 1, back down to 4.
    move(1);
    move(1);
    move(1);
    move(2);
    move(2);
    move(3);
    move(3);
    check("cursor_home", 32'(bus.cursor), 32'h010);

    // Long place press: one pulse, C held through the gap and until release.
    expect_place(9'h000);
    @(negedge clk);
    drive(5'b10000);
    n = 0;
    while (!bus.writeEn && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("we_rise", 32'(bus.writeEn), 32'd1);
    while (bus.writeEn && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("we_fall", 32'(bus.writeEn), 32'd0);
    for (int i = 0; i < We; i++) begin
      check("gap_c", 32'(bus.C), 32'h010);
      check("gap_we", 32'(bus.writeEn), 32'd0);
      @(negedge clk);
      n++;
    end
    while (n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hold_c", 32'(bus.C), 32'h010);
    check("hold_we", 32'(bus.writeEn), 32'd0);
    drive(5'b0);
    repeat (20) @(negedge clk);

    // Occupied cell, then game over: both rejected.
    bus.X = 9'(1) << cur;
    push(KReject, 9'h000, "reject_occ");
    press(5'b10000, 10);
    bus.X         = '0;
    bus.game_over = 1'b1;
    push(KReject, 9'h000, "reject_over");
    press(5'b10000, 10);
    bus.game_over = 1'b0;

    // Place and left together: place wins, cursor stays.
    expect_place(9'h000);
    press(5'b10001, 10);
    repeat (6) @(negedge clk);

    // Reset during WRITE.
    move(1);
    push(KC, 9'(1) << cur, "c_before_rst");
    @(negedge clk);
    drive(5'b10000);
    n = 0;
    while (!bus.writeEn && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("we_rise_rst", 32'(bus.writeEn), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("async_we", 32'(bus.writeEn), 32'd0);
    check("async_c", 32'(bus.C), 32'h0);
    drive(5'b0);
    repeat (3) @(negedge clk);
    check("rst_cursor2", 32'(bus.cursor), 32'h010);
    cur   = 4;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    mon_en = 1'b1;

    // Nearly full boards.
    bus.X = 9'h1EF;
    expect_place(9'h1EF);
    press(5'b10000, 10);
    bus.X = 9'h0FF;
    move(1);
    move(3);
    expect_place(9'h0FF);
    press(5'b10000, 10);
    bus.X = '0;

    repeat (10) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("unexpected_events", 32'(n_unexp), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/move_select.md
Name: move_select

Overview:
- Upstream feeder of the tic-tac-toe game state register, i.e. the block holding the X/O boards.
- Turns raw board push-buttons into a movable cursor and a validated one-hot cell strobe.
- Drives that register's C and writeEn inputs. Occupied cells and moves after game end are rejected.
- writeEn is a level that must drop between moves, so the block guarantees a low gap before re-arming.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized cycles before a debounced button changes state.
- WE_CYCLES, 4: cycles writeEn is held high; also the minimum low gap after it.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn_left / btn_right / btn_up / btn_down  input  1 each  raw asynchronous buttons, active-high
- btn_place  input  1  raw asynchronous place button, active-high
- X  input  9  X board from state register; bit i = cell i, row-major, bit 0 top-left
- O  input  9  O board, same encoding as X
- game_over  input  1  high blocks all placements
- C  output  9  one-hot cell to write; 0 when idle
- writeEn  output  1  write strobe to state register
- cursor  output  9  one-hot cursor position for display
- reject  output  1  one-cycle pulse on a refused placement

Behaviour:
- Reset (asynchronous, reset=0):
  - cursor=9'b000010000 (cell 4).
  - C=0, writeEn=0, reject=0.
  - FSM=IDLE; all synchronizers, debounce counters and debounced levels cleared to 0.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: counts while synchronized value differs from debounced value, clears otherwise. At DEBOUNCE_CYCLES-1 the debounced value flips and the counter clears.
  - Rising-edge detect on the debounced value gives a 1-cycle press.
  - Latency from raw rise: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Cursor moves (IDLE only; presses in other states are discarded):
  - Left/right: column -1/+1, wrapping within the row (0←→2).
  - Up/down: row -1/+1, wrapping within the column.
  - Cursor is held internally as index 0..8 and output one-hot.
- Same-cycle presses:
  - Priority: place > left > right > up > down.
  - Only the winner acts; other presses in that cycle are dropped.
- FSM states: IDLE, WRITE, GAP, HOLD.
- IDLE:
  - On place press, if game_over=1 or (X|O)[cursor]=1: reject=1 for one cycle, stay IDLE, C stays 0.
  - Otherwise: C<=onehot(cursor), writeEn<=1, load timer with WE_CYCLES-1, go WRITE.
- WRITE:
  - C and writeEn held; timer decrements.
  - At timer 0: writeEn<=0, reload timer with WE_CYCLES-1, go GAP.
- GAP:
  - writeEn=0, C held; timer decrements.
  - At 0, go HOLD.
- HOLD:
  - Wait until debounced place=0, then C<=0 and go IDLE.
  - A long press therefore commits exactly one move.
- game_over going high during WRITE/GAP/HOLD does not abort; the sequence completes.
- Board inputs are sampled only in the IDLE decision cycle.
- Reset asserted mid-sequence: writeEn and C drop asynchronously to 0, FSM returns to IDLE.
- writeEn never rises in consecutive cycles without at least WE_CYCLES low cycles between.

Optional Feature:
- Macro: MOVE_SELECT_AUTO_ADVANCE_EN.
- Defined:
  - On HOLD→IDLE, cursor jumps to the lowest-index empty cell of (X|O) strictly after the current index, wrapping from 8 to 0.
  - If no empty cell exists, cursor is unchanged.
  - Search is combinational over 9 bits, applied in the transition cycle.
- Undefined: cursor stays on the placed cell; no search logic is present.

Test Plan (DEBOUNCE_CYCLES=4, WE_CYCLES=4):
- Reset release, no buttons → cursor=9'h010, C=0, writeEn=0, reject=0 indefinitely.
- Press right 3 times from reset → cursor goes 9'h020, 9'h008, 9'h010 (wrap within row 1). Then up twice → 9'h002, 9'h080.
- X=O=0, place at cell 4 held 40 cycles:
  - C=9'h010 with writeEn=1 for exactly 4 cycles, then writeEn=0 with C=9'h010 for 4 cycles.
  - C returns 0 only after release debounces.
  - Exactly one writeEn pulse.
- X=9'h010, place at cell 4 → reject=1 for one cycle, writeEn stays 0, C stays 0. Same with X=O=0 and game_over=1.
- Place and left asserted same cycle → placement occurs, cursor unchanged. Reset asserted in WRITE → writeEn=0, C=0 immediately; after release, cursor=9'h010.
- With MOVE_SELECT_AUTO_ADVANCE_EN, X=9'h1EF, O=0, place at cell 4 → after HOLD, cursor=9'h010. With X=9'h0FF, place at cell 8 → cursor=9'h100 (board full, unchanged).
